fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 14 +
 rtl/fetch_queue_fifo.sv | 52 +++++
 rtl/fetch_queue.sv | 98 +++++++++
 tb/tb_fetch_queue.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared CPU fetch definitions: reset vector, PC step, default queue depth
// and the layout of one queued fetch entry.
package fetch_queue_pkg;

    localparam int unsigned FQ_DEPTH      = 4;
    localparam logic [15:0] FQ_RESET_ADDR = 16'h0000;
    localparam logic [15:0] PC_INC        = 16'd2;

    typedef struct packed {
        logic [15:0] instruction;
        logic [15:0] pc_next;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// Circular entry store for the fetch queue. Occupancy is tracked by the
// owner, which guarantees no push ever lands on a full buffer.
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = FQ_DEPTH
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      push_i,
    input  fq_entry_t push_data_i,
    input  logic      pop_i,
    input  logic      flush_i,
    output fq_entry_t head_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    fq_entry_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues in-order imem requests, reserves a slot per
// outstanding request, and squashes stale responses after a redirect.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH      = FQ_DEPTH,
    parameter logic [15:0] RESET_ADDR = FQ_RESET_ADDR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect,
    input  logic [15:0] redirect_addr,
    input  logic        halt,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    output logic        id_valid,
    output logic [15:0] id_instruction,
    output logic [15:0] id_pc_next,
    input  logic        id_ready
);

    localparam int unsigned CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [15:0]   fetch_pc_q, fetch_pc_d;
    logic [15:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW:0]   occupancy;
    logic          accept, rsp, push, pop;
    fq_entry_t     push_data, head;

    // Every outstanding request owns a queue slot, so a response always fits.
    assign occupancy = (CW+1)'(count_q) + (CW+1)'(outst_q);
    assign imem_req  = !reset && !redirect && !halt && (occupancy < DEPTH_W);
    assign imem_addr = fetch_pc_q;
    assign accept    = imem_req && imem_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp       = imem_rvalid && (outst_q != '0);
    assign push      = rsp && (discard_q == '0) && !redirect;
    assign id_valid  = !reset && (count_q != '0);
    assign pop       = id_valid && id_ready && !redirect;
    assign push_data = '{instruction: imem_rdata, pc_next: resp_pc_q + PC_INC};

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        count_d    = count_q;
        discard_d  = discard_q;
        outst_d    = outst_q + CW'(accept) - CW'(rsp);
        if (redirect) begin
            fetch_pc_d = redirect_addr;
            resp_pc_d  = redirect_addr;
            count_d    = '0;
            discard_d  = outst_d;
        end else begin
            if (accept) fetch_pc_d = fetch_pc_q + PC_INC;
            if (push)   resp_pc_d  = push_data.pc_next;
            count_d   = count_q + CW'(push) - CW'(pop);
            discard_d = discard_q - CW'(rsp && (discard_q != '0));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q <= RESET_ADDR;
            resp_pc_q  <= RESET_ADDR;
            count_q    <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .flush_i     (redirect),
        .head_o      (head)
    );

    assign id_instruction = head.instruction;
    assign id_pc_next     = head.pc_next;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: an in-order latency memory drives the DUT
// and a queue-level model of the fetch rules checks every cycle.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1, redirect = 1'b0, halt = 1'b0;
    logic        imem_ready = 1'b1, imem_rvalid = 1'b0, id_ready = 1'b1;
    logic [15:0] redirect_addr = '0, imem_rdata = '0;
    logic        imem_req, id_valid;
    logic [15:0] imem_addr, id_instruction, id_pc_next;

    always #5 clock = ~clock;

    fetch_queue #(.DEPTH(DEPTH), .RESET_ADDR(16'h0000)) dut (
        .clock(clock), .reset(reset), .redirect(redirect), .redirect_addr(redirect_addr),
        .halt(halt), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .id_valid(id_valid),
        .id_instruction(id_instruction), .id_pc_next(id_pc_next), .id_ready(id_ready)
    );

    typedef struct { int due; logic [15:0] addr; } pend_t;
    typedef struct { logic [15:0] addr; bit stale; } infl_t;
    typedef struct { logic [15:0] ins; logic [15:0] pcn; } ent_t;

    pend_t       pend[$];   // memory: accepted requests awaiting their response slot
    infl_t       infl[$];   // model: requests in flight, oldest first
    ent_t        mq[$];     // model: queued entries, head first
    logic [15:0] m_fetch_pc = 16'h0000;
    logic [15:0] reqlog[$], pclog[$], inslog[$];
    int          nvec = 0, nerr = 0, cyc = 0, lat = 1;
    bit          spurious = 1'b0;

    function automatic logic [15:0] memf(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: present memory response, check outputs, advance model and memory.
    task automatic step();
        bit    mem_hit, rsp, exp_req;
        infl_t f;
        mem_hit = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (!reset) begin
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memf(pend[0].addr);
                mem_hit     = 1'b1;
            end else if (spurious) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 16'hDEAD;
            end
        end
        #1;
        exp_req = !reset && !redirect && !halt && (mq.size() + infl.size() < DEPTH);
        if (reset) begin
            chk("req_in_reset", imem_req, 0);
            chk("valid_in_reset", id_valid, 0);
        end else begin
            chk("imem_req", imem_req, exp_req);
            if (exp_req) chk("imem_addr", imem_addr, m_fetch_pc);
            chk("id_valid", id_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                chk("id_instruction", id_instruction, mq[0].ins);
                chk("id_pc_next", id_pc_next, mq[0].pcn);
            end
            if (imem_req && imem_ready) reqlog.push_back(imem_addr);
            if (id_valid && id_ready && !redirect) begin
                pclog.push_back(id_pc_next);
                inslog.push_back(id_instruction);
            end
        end
        if (reset) begin
            mq.delete();
            infl.delete();
            m_fetch_pc = 16'h0000;
        end else begin
            rsp = imem_rvalid && infl.size() > 0;
            if (redirect) begin
                if (rsp) void'(infl.pop_front());
                foreach (infl[i]) infl[i].stale = 1'b1;
                mq.delete();
                m_fetch_pc = redirect_addr;
            end else begin
                if (mq.size() > 0 && id_ready) void'(mq.pop_front());
                if (rsp) begin
                    f = infl.pop_front();
                    if (!f.stale) mq.push_back('{ins: memf(f.addr), pcn: f.addr + 16'd2});
                end
                if (exp_req && imem_ready) begin
                    infl.push_back('{addr: m_fetch_pc, stale: 1'b0});
                    m_fetch_pc = m_fetch_pc + 16'd2;
                end
            end
        end
        if (reset) pend.delete();
        else begin
            if (mem_hit) void'(pend.pop_front());
            if (imem_req && imem_ready) pend.push_back('{due: cyc + lat, addr: imem_addr});
        end
        cyc++;
        @(negedge clock);
    endtask

    initial begin
        @(negedge clock);
        // Reset, then a 1-cycle memory streaming from 0000
        reset = 1'b1; step(); step();
        reset = 1'b0; lat = 1;
        repeat (10) step();
        chk("stream_n", reqlog.size() >= 4 && pclog.size() >= 4, 1);
        if (reqlog.size() >= 4 && pclog.size() >= 4) begin
            chk("req0", reqlog[0], 16'h0000); chk("req1", reqlog[1], 16'h0002);
            chk("req2", reqlog[2], 16'h0004); chk("req3", reqlog[3], 16'h0006);
            chk("pc0", pclog[0], 16'h0002);   chk("pc1", pclog[1], 16'h0004);
            chk("pc2", pclog[2], 16'h0006);   chk("pc3", pclog[3], 16'h0008);
        end

        // Decode stalled for 10 cycles fills the queue, then drains with a ready gap
        id_ready = 1'b0;
        repeat (10) step();
        chk("fill_model", mq.size(), 4);
        chk("full_no_req", imem_req, 0);
        chk("full_valid", id_valid, 1);
        id_ready = 1'b1;
        repeat (8) step();
        imem_ready = 1'b0; repeat (3) step();
        imem_ready = 1'b1; repeat (4) step();
        chk("drain_n", pclog.size() >= 16, 1);
        for (int i = 1; i < pclog.size(); i++) chk("pc_seq", pclog[i], pclog[i-1] + 16'd2);

        // 3-cycle memory, two outstanding, redirect to 0040
        reset = 1'b1; lat = 3; step();
        reset = 1'b0; step(); step();
        chk("two_outstanding", infl.size(), 2);
        redirect = 1'b1; redirect_addr = 16'h0040; pclog.delete(); inslog.delete();
        step();
        redirect = 1'b0;
        repeat (10) step();
        chk("redir_n", pclog.size() >= 1, 1);
        if (pclog.size() >= 1) begin
            chk("redir_pc", pclog[0], 16'h0042);
            chk("redir_ins", inslog[0], 16'hC3E5);
        end

        // Redirect colliding with a response and a pop
        reset = 1'b1; lat = 1; step();
        reset = 1'b0; repeat (5) step();
        chk("pre_redir_valid", id_valid, 1);
        redirect = 1'b1; redirect_addr = 16'h0100; step();
        redirect = 1'b0; #1;
        chk("redir_empty", id_valid, 0);
        chk("redir_req", imem_req, 1);
        chk("redir_addr", imem_addr, 16'h0100);
        repeat (6) step();

        // Halt with two outstanding
        reset = 1'b1; lat = 3; step();
        reset = 1'b0; reqlog.delete(); pclog.delete();
        step(); step();
        halt = 1'b1; repeat (6) step();
        chk("halt_reqs", reqlog.size(), 2);
        chk("halt_enq", pclog.size(), 2);
        if (pclog.size() == 2) begin
            chk("halt_pc0", pclog[0], 16'h0002);
            chk("halt_pc1", pclog[1], 16'h0004);
        end
        halt = 1'b0; #1;
        chk("resume_req", imem_req, 1);
        chk("resume_addr", imem_addr, 16'h0004);
        repeat (4) step();

        // Address wrap from FFFC, then reset mid-stream
        reset = 1'b1; lat = 1; step();
        reset = 1'b0; redirect = 1'b1; redirect_addr = 16'hFFFC; step();
        redirect = 1'b0; reqlog.delete(); pclog.delete();
        repeat (6) step();
        chk("wrap_n", reqlog.size() >= 3 && pclog.size() >= 3, 1);
        if (reqlog.size() >= 3 && pclog.size() >= 3) begin
            chk("wreq0", reqlog[0], 16'hFFFC); chk("wreq1", reqlog[1], 16'hFFFE);
            chk("wreq2", reqlog[2], 16'h0000);
            chk("wpc0", pclog[0], 16'hFFFE);   chk("wpc1", pclog[1], 16'h0000);
            chk("wpc2", pclog[2], 16'h0002);
        end
        reset = 1'b1; step();
        reset = 1'b0; #1;
        chk("post_reset_req", imem_req, 1);
        chk("post_reset_addr", imem_addr, 16'h0000);
        repeat (3) step();

        // Response with nothing outstanding is ignored
        reset = 1'b1; step();
        reset = 1'b0; halt = 1'b1; step();
        spurious = 1'b1; step();
        spurious = 1'b0; step();
        chk("spur_valid", id_valid, 0);
        halt = 1'b0; pclog.delete();
        repeat (5) step();
        chk("spur_n", pclog.size() >= 1, 1);
        if (pclog.size() >= 1) chk("spur_pc", pclog[0], 16'h0002);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
